// File: rtl/conv_pkg.sv
// Shared types and default constants for the batch conversion sequencer.
package conv_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ARMED,
        FETCH,
        LOAD,
        ISSUE,
        WAIT,
        STORE,
        ADVANCE,
        DONE
    } state_e;

    localparam int N_ITEMS_DEF     = 25;
    localparam int ADDR_W_DEF      = 5;
    localparam int DATA_W_DEF      = 32;
    localparam int TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/conv_batch_sequencer_if.sv
// Source buffer, converter and destination buffer signals of the sequencer.
// master: the sequencer side; slave: buffers/converter side.
interface conv_batch_sequencer_if
    import conv_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              src_rd;
    logic [ADDR_W-1:0] src_addr;
    logic [DATA_W-1:0] src_data;
    logic              conv_start;
    logic [DATA_W-1:0] conv_in;
    logic              conv_done;
    logic [DATA_W-1:0] conv_out;
    logic              dst_wr;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] dst_data;

    modport master (
        output src_rd, src_addr, conv_start, conv_in, dst_wr, dst_addr, dst_data,
        input  src_data, conv_done, conv_out
    );

    modport slave (
        input  src_rd, src_addr, conv_start, conv_in, dst_wr, dst_addr, dst_data,
        output src_data, conv_done, conv_out
    );
endinterface

// File: rtl/conv_watchdog.sv
// Converter watchdog: counts cycles while enabled, flags expiry on the
// TIMEOUT_CYC-th enabled cycle. Only built when CONV_TIMEOUT_EN is defined.
module conv_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;

    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Count enabled cycles; clear takes priority, hold once expired.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (en_i && !expired_o)
            cnt_q <= cnt_q + CW'(1);
    end
endmodule

// File: rtl/conv_batch_sequencer.sv
// Batch sequencer: walks N_ITEMS words from the source buffer through a
// shared multi-cycle converter into the destination buffer, then pulses done.
// Optional: CONV_TIMEOUT_EN adds a converter watchdog and the sticky err flag.
module conv_batch_sequencer
    import conv_pkg::*;
#(
    parameter int N_ITEMS     = N_ITEMS_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    conv_batch_sequencer_if.master bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [ADDR_W-1:0]      count_o,
    output logic                   err_o
);
    // One extra bit so N_ITEMS == 2**ADDR_W compares without wrapping.
    localparam int CNT_W = ADDR_W + 1;

    if (N_ITEMS < 1 || N_ITEMS > (2 ** ADDR_W) || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("conv_batch_sequencer: illegal N_ITEMS/ADDR_W/TIMEOUT_CYC");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0] conv_in_q, conv_in_d;
    logic [DATA_W-1:0] dst_data_q, dst_data_d;
    logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
    logic              busy_q, busy_d;
    logic              wd_expired;

`ifdef CONV_TIMEOUT_EN
    logic err_q, err_d;
    logic wd_clr, wd_en;

    conv_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wd (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    // Sticky timeout flag, cleared when a batch is launched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign wd_expired = 1'b0;
    assign err_o      = 1'b0;
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and datapath-load decode; everything holds by default.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        conv_in_d  = conv_in_q;
        dst_data_d = dst_data_q;
        dst_addr_d = dst_addr_q;
        busy_d     = busy_q;
`ifdef CONV_TIMEOUT_EN
        err_d      = err_q;
        wd_clr     = 1'b0;
        wd_en      = 1'b0;
`endif
        case (state_q)
            IDLE:  if (start_i) state_d = ARMED;
            ARMED: if (!start_i) begin
                cnt_d   = '0;
                busy_d  = 1'b1;
`ifdef CONV_TIMEOUT_EN
                err_d   = 1'b0;
`endif
                state_d = FETCH;
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                conv_in_d = bus.src_data;
                state_d   = ISSUE;
            end
            ISSUE: begin
`ifdef CONV_TIMEOUT_EN
                wd_clr  = 1'b1;
`endif
                state_d = WAIT;
            end
            WAIT: begin
`ifdef CONV_TIMEOUT_EN
                wd_en = 1'b1;
`endif
                if (bus.conv_done) begin
                    dst_data_d = bus.conv_out;
                    dst_addr_d = cnt_q[ADDR_W-1:0];
                    state_d    = STORE;
                end else if (wd_expired) begin
                    dst_data_d = '0;
                    dst_addr_d = cnt_q[ADDR_W-1:0];
`ifdef CONV_TIMEOUT_EN
                    err_d      = 1'b1;
`endif
                    state_d    = STORE;
                end
            end
            STORE: state_d = ADVANCE;
            ADVANCE: begin
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == CNT_W'(N_ITEMS)) ? DONE : FETCH;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Registered datapath: item counter, operand, result, write address, busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            conv_in_q  <= '0;
            dst_data_q <= '0;
            dst_addr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            conv_in_q  <= conv_in_d;
            dst_data_q <= dst_data_d;
            dst_addr_q <= dst_addr_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.src_rd     = (state_q == FETCH);
    assign bus.src_addr   = cnt_q[ADDR_W-1:0];
    assign bus.conv_start = (state_q == ISSUE);
    assign bus.conv_in    = conv_in_q;
    assign bus.dst_wr     = (state_q == STORE);
    assign bus.dst_addr   = dst_addr_q;
    assign bus.dst_data   = dst_data_q;
    assign done_o         = (state_q == DONE);
    assign busy_o         = busy_q;
    assign count_o        = cnt_q[ADDR_W-1:0];
endmodule
